mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 17 +
 rtl/mem_req_arbiter_fifo.sv | 33 +++
 rtl/mem_req_arbiter.sv | 62 ++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared memory request/response types and arbiter state encoding.
package ShellTypes;
  localparam int NUM_MEM_CLIENTS = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic              valid;
    logic              isWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } MemReq;
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } MemResp;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} ArbState;
endpackage

// File: rtl/mem_req_arbiter_fifo.sv
// mem_req_arbiter_fifo: 2**LOG_DEPTH entry FIFO, show-ahead head, extra pointer bit tells full from empty.
module mem_req_arbiter_fifo #(
  parameter int WIDTH = 1,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] r_mem [2**LOG_DEPTH];
  logic [LOG_DEPTH:0] r_wp, r_rp;
  logic w_wr, w_rd;
  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;
  assign o_empty = r_wp == r_rp;
  assign o_full = (r_wp[LOG_DEPTH] != r_rp[LOG_DEPTH]) && (r_wp[LOG_DEPTH-1:0] == r_rp[LOG_DEPTH-1:0]);
  assign o_dout = r_mem[r_rp[LOG_DEPTH-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp[LOG_DEPTH-1:0]] <= i_din;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin two-client memory arbiter with owner lock and read-tag response routing.
module mem_req_arbiter
  import ShellTypes::*;
#(
  parameter int LOG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  MemReq  [NUM_MEM_CLIENTS-1:0] req_in,
  output logic   [NUM_MEM_CLIENTS-1:0] req_grant_out,
  output MemResp [NUM_MEM_CLIENTS-1:0] resp_out,
  input  logic   [NUM_MEM_CLIENTS-1:0] resp_grant_in,
  output MemReq                        mem_req_out,
  input  logic                         mem_req_grant_in,
  input  MemResp                       mem_resp_in,
  output logic                         mem_resp_grant_out,
  output logic   [LOG_DEPTH:0]         outstanding_out,
  output logic                         err_out
);
  ArbState r_state, w_nxt;
  logic r_last;
  logic [1:0] w_v, w_elig;
  logic w_cand, w_own, w_pres, w_gnt, w_push, w_pop, w_rv, w_id, w_full, w_empty;
  mem_req_arbiter_fifo #(.WIDTH(1), .LOG_DEPTH(LOG_DEPTH)) u_tags (
    .clk(clk), .rst(rst), .i_push(w_push), .i_din(w_own), .i_pop(w_pop),
    .o_dout(w_id), .o_full(w_full), .o_empty(w_empty)
  );
  always_comb begin
    w_v = {req_in[1].valid, req_in[0].valid};
    w_elig = w_v & ({req_in[1].isWrite, req_in[0].isWrite} | {2{!w_full}});
    w_cand = r_state == OWN0 ? 1'b0 : r_state == OWN1 ? 1'b1 : (&w_v ? !r_last : !w_v[0]);
    // a blocked read yields to the other client without touching the fairness pointer
    w_own = (!w_elig[w_cand] && w_elig[!w_cand]) ? !w_cand : w_cand;
    w_pres = w_elig[w_own] && !rst;
    w_gnt = w_pres && mem_req_grant_in;
    w_push = w_gnt && !req_in[w_own].isWrite;
    mem_req_out = rst ? '0 : req_in[w_own];
    mem_req_out.valid = w_pres;
    req_grant_out = '0;
    req_grant_out[w_own] = w_gnt;
    w_nxt = w_gnt ? (w_v[!w_own] ? (w_own ? OWN0 : OWN1) : IDLE) : w_pres ? (w_own ? OWN1 : OWN0) : IDLE;
    w_rv = mem_resp_in.valid && !w_empty && !rst;
    w_pop = w_rv && resp_grant_in[w_id];
    mem_resp_grant_out = w_pop;
    resp_out = '0;
    resp_out[w_id] = rst ? '0 : mem_resp_in;
    resp_out[w_id].valid = w_rv;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      outstanding_out <= '0;
      err_out <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_gnt) r_last <= w_own;
      if (w_push && !w_pop) outstanding_out <= outstanding_out + 1'b1;
      else if (w_pop && !w_push) outstanding_out <= outstanding_out - 1'b1;
      if (mem_resp_in.valid && w_empty) err_out <= 1'b1;
    end
endmodule
